// File: rtl/mips_io_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
// Register offsets, STATUS bit positions and TX FSM states.
package mips_io_pkg;
  localparam logic [3:0] TXDATA_OFS = 4'h0;
  localparam logic [3:0] STATUS_OFS = 4'h4;

  localparam int BUSY  = 0;
  localparam int FULL  = 1;
  localparam int EMPTY = 2;
  localparam int OVF   = 3;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; a push while full is taken only
// when a pop is accepted in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 serial transmitter sitting beside data memory;
// decodes the I/O window, queues bytes and shifts them out.
module mmio_uart_tx #(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FFF0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_write,
  output logic [31:0] rdata,
  output logic        io_sel,
  output logic        dmem_we,
  output logic        tx,
  output logic        tx_busy
);
  import mips_io_pkg::*;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int FW = $clog2(FIFO_DEPTH);

  tx_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        ovf_q, ovf_d;

  logic        wr_tx, wr_st, pop, drop, last;
  logic        f_full, f_empty;
  logic [7:0]  f_dout;
  logic [FW:0] f_cnt;
  logic [3:0]  status;
  logic        unused_ok;

  assign io_sel  = (addr[31:4] == BASE_ADDR[31:4]);
  assign dmem_we = mem_write & ~io_sel;
  assign wr_tx   = mem_write & io_sel & (addr[3:0] == TXDATA_OFS);
  assign wr_st   = mem_write & io_sel & (addr[3:0] == STATUS_OFS);
  // A full FIFO still accepts a byte when the FSM drains one this cycle.
  assign drop    = wr_tx & f_full & ~pop;

  assign tx_busy = (state_q != IDLE) | ~f_empty;
  assign tx      = tx_q;

  always_comb begin
    status        = '0;
    status[BUSY]  = tx_busy;
    status[FULL]  = f_full;
    status[EMPTY] = f_empty;
    status[OVF]   = ovf_q;
    rdata         = '0;
    if (io_sel && addr[3:0] == STATUS_OFS) rdata = {28'b0, status};
  end

  assign unused_ok = ^{wdata[31:8], f_cnt};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_tx),
    .din   (wdata[7:0]),
    .pop   (pop),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty),
    .count (f_cnt)
  );

  assign last = (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!f_empty) begin
          pop     = 1'b1;
          shift_d = f_dout;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (last) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end else cnt_d = cnt_q + CW'(1);
      end
      DATA: begin
        if (last) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else bit_d = bit_q + 3'd1;
        end else cnt_d = cnt_q + CW'(1);
      end
      STOP: begin
        if (last) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else cnt_d = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level follows the state being entered so tx stays registered.
  always_comb begin
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (wr_st && wdata[OVF]) ovf_d = 1'b0;
    if (drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule
